// File: rtl/readout_rx_meas_scheduler.sv
// rtl/readout_rx_meas_scheduler.sv - round-robin scheduler sharing one measurement decision unit among readout channels
// Optional watchdog: RX_MEAS_SCHED_TIMEOUT_EN
module readout_rx_meas_scheduler #(
  parameter int NUM_CH         = 8,
  parameter int CH_ID_WIDTH    = 3,
  parameter int GUARD_CYCLES   = 4,
  parameter int GUARD_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 1500,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req_in,
  output logic [NUM_CH-1:0]      req_ack_out,
  output logic                   start_count_out,
  output logic [CH_ID_WIDTH-1:0] bin_sel_out,
  input  logic                   decision_fin_in,
  input  logic                   decision_state_in,
  output logic                   result_valid_out,
  input  logic                   result_ready_in,
  output logic [CH_ID_WIDTH-1:0] result_ch_out,
  output logic                   result_bit_out,
  output logic                   result_timeout_out,
  output logic                   busy_out
);

  typedef enum logic [2:0] {IDLE, GRANT, RUN, REPORT, GUARD} state_t;

  state_t                 state, state_next;
  logic [CH_ID_WIDTH-1:0] rr_ptr, cur_ch, pick_ch, result_ch;
  logic                   pick_found, result_bit, timeout_hit, run_done;
  logic [GUARD_WIDTH-1:0] guard_cnt;
  logic [2*NUM_CH-1:0]    req_rot;
  logic [CH_ID_WIDTH:0]   pick_sum;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the next channel in round-robin order.
  always_comb begin
    req_rot    = {req_in, req_in} >> rr_ptr;
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (CH_ID_WIDTH + 1)'(i);
      end
    end
    if (pick_sum >= (CH_ID_WIDTH + 1)'(NUM_CH)) pick_sum = pick_sum - (CH_ID_WIDTH + 1)'(NUM_CH);
    pick_ch = pick_sum[CH_ID_WIDTH-1:0];
  end

  assign run_done = decision_fin_in || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = GRANT;
      GRANT:   state_next = RUN;
      RUN:     if (run_done) state_next = REPORT;
      REPORT:  if (result_ready_in) state_next = (GUARD_CYCLES > 0) ? GUARD : IDLE;
      GUARD:   if (guard_cnt == GUARD_WIDTH'(GUARD_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cur_ch     <= '0;
      result_ch  <= '0;
      result_bit <= 1'b0;
      guard_cnt  <= '0;
    end else begin
      if (state == IDLE && pick_found) cur_ch <= pick_ch;
      if (state == GRANT)
        rr_ptr <= (cur_ch == CH_ID_WIDTH'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
      if (state == RUN && run_done) begin
        result_ch  <= cur_ch;
        result_bit <= decision_fin_in & decision_state_in;
      end
      if (state == GUARD) guard_cnt <= guard_cnt + 1'b1;
      else                guard_cnt <= '0;
    end
  end

`ifdef RX_MEAS_SCHED_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic                     result_timeout;

  // A decision arriving in the expiry cycle takes precedence over the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt         <= '0;
      result_timeout <= 1'b0;
    end else begin
      if (state == RUN) wd_cnt <= wd_cnt + 1'b1;
      else              wd_cnt <= '0;
      if (state == RUN && run_done) result_timeout <= ~decision_fin_in;
    end
  end

  assign timeout_hit        = (state == RUN) && (wd_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign result_timeout_out = result_timeout;
`else
  // No watchdog: the expression is constant 0 and only keeps the parameters referenced.
  assign timeout_hit        = (TIMEOUT_CYCLES < 0) && (TIMEOUT_WIDTH < 0);
  assign result_timeout_out = 1'b0;
`endif

  assign req_ack_out      = (state == GRANT) ? (NUM_CH'(1) << cur_ch) : '0;
  assign start_count_out  = (state == GRANT);
  assign bin_sel_out      = cur_ch;
  assign result_valid_out = (state == REPORT);
  assign result_ch_out    = result_ch;
  assign result_bit_out   = result_bit;
  assign busy_out         = (state != IDLE);

endmodule

// File: tb/tb_readout_rx_meas_scheduler.sv
// tb/tb_readout_rx_meas_scheduler.sv - directed and randomized checks of the measurement scheduler against a transaction model
module tb_readout_rx_meas_scheduler;
  localparam int N = 8;
  localparam int G = 4;

  logic clk = 1'b0;
  logic rst, fin, st, ready;
  logic [N-1:0] req, ack;
  logic start, valid, rbit, rto, busy;
  logic [2:0] bin_sel, rch;

  readout_rx_meas_scheduler dut (
    .clk(clk), .rst(rst), .req_in(req), .req_ack_out(ack), .start_count_out(start),
    .bin_sel_out(bin_sel), .decision_fin_in(fin), .decision_state_in(st),
    .result_valid_out(valid), .result_ready_in(ready), .result_ch_out(rch),
    .result_bit_out(rbit), .result_timeout_out(rto), .busy_out(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Transaction-level model: who owns the decision unit and what is owed to the consumer.
  int m_owner, m_rr, m_last, m_guard, m_res_ch;
  bit m_gnow, m_have, m_res_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_last = 0; m_guard = 0;
    m_res_ch = 0; m_res_bit = 0; m_gnow = 0; m_have = 0;
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (m_gnow) begin
      m_gnow = 0;
      m_rr = (m_owner + 1) % N;
    end else if (m_owner >= 0 && !m_have) begin
      if (fin) begin
        m_have = 1; m_res_ch = m_owner; m_res_bit = st;
      end
    end else if (m_have) begin
      if (ready) begin
        m_have = 0; m_owner = -1; m_guard = G;
      end
    end else if (m_guard > 0) m_guard--;
    else if (req != 0) begin
      m_owner = rr_pick(req, m_rr);
      m_last = m_owner;
      m_gnow = 1;
    end
  endtask

  task automatic compare();
    check("ack", 32'(ack), m_gnow ? (32'd1 << m_owner) : 32'd0);
    check("start", 32'(start), 32'(m_gnow));
    check("bin_sel", 32'(bin_sel), 32'(m_last));
    check("valid", 32'(valid), 32'(m_have));
    check("busy", 32'(busy), 32'(m_owner >= 0 || m_guard > 0));
    check("timeout", 32'(rto), 32'd0);
    if (m_have) begin
      check("res_ch", 32'(rch), 32'(m_res_ch));
      check("res_bit", 32'(rbit), 32'(m_res_bit));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    compare();
  endtask

  int order[4];
  int got;

  initial begin
    model_reset();
    rst = 1; req = '0; fin = 0; st = 0; ready = 0;
    tick(); tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_start", 32'(start), 32'h0);
    check("rst_bin", 32'(bin_sel), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_res", {29'd0, rch} | 32'(rbit), 32'h0);

    // single request on channel 0
    rst = 0; req = 8'h01;
    tick();
    check("t1_ack", 32'(ack), 32'h01);
    check("t1_start", 32'(start), 32'h1);
    check("t1_bin", 32'(bin_sel), 32'h0);
    req = 8'h00;
    tick();
    check("t1_nostart", 32'(start), 32'h0);
    fin = 1; st = 1;
    tick();
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_ch", 32'(rch), 32'h0);
    check("t1_bit", 32'(rbit), 32'h1);
    fin = 0; ready = 1;
    tick();
    ready = 0;
    check("t1_guard", 32'(busy), 32'h1);
    repeat (3) begin tick(); check("t1_guard_n", 32'(busy), 32'h1); end
    tick();
    check("t1_idle", 32'(busy), 32'h0);

    // result held stable while consumer stalls; pending request waits
    req = 8'h08; tick(); req = 8'h00; tick();
    fin = 1; st = 0; tick(); fin = 0;
    req = 8'h20;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(valid), 32'h1);
      check("hold_ch", 32'(rch), 32'h3);
      check("hold_ack", 32'(ack), 32'h0);
    end
    ready = 1; tick(); ready = 0;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (ack != 0) got = 1;
    end
    check("hold_next_ack", 32'(ack), 32'h20);
    req = 8'h00;
    tick(); fin = 1; st = 1; tick(); fin = 0; ready = 1; tick(); ready = 0;

    // decision_fin ignored in GUARD and IDLE
    fin = 1; tick(); tick(); fin = 0;
    check("fin_guard_valid", 32'(valid), 32'h0);
    repeat (3) tick();
    fin = 1; tick(); fin = 0;
    check("fin_idle_busy", 32'(busy), 32'h0);
    check("fin_idle_valid", 32'(valid), 32'h0);

    // round-robin order with wrap, from a fresh reset
    rst = 1; tick(); rst = 0;
    req = 8'h85; fin = 1; ready = 1;
    for (int i = 0; i < 4; i++) order[i] = -1;
    got = 0;
    for (int i = 0; i < 80 && got < 4; i++) begin
      tick();
      for (int b = 0; b < N; b++)
        if (ack[b] && got < 4) begin order[got] = b; got++; end
    end
    check("rr_count", 32'(got), 32'd4);
    check("rr_0", 32'(order[0]), 32'd0);
    check("rr_1", 32'(order[1]), 32'd2);
    check("rr_2", 32'(order[2]), 32'd7);
    check("rr_3", 32'(order[3]), 32'd0);
    req = 8'h00; fin = 0; ready = 0;
    rst = 1; tick(); rst = 0;

    // reset during RUN aborts; afterwards arbitration restarts at channel 0
    req = 8'h10; tick();
    check("rr_ack4", 32'(ack), 32'h10);
    tick();
    req = 8'h50; rst = 1; tick(); rst = 0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ack", 32'(ack), 32'h0);
    check("abort_bin", 32'(bin_sel), 32'h0);
    check("abort_valid", 32'(valid), 32'h0);
    tick();
    check("abort_regrant", 32'(ack), 32'h10);
    check("abort_bin4", 32'(bin_sel), 32'h4);
    req = 8'h00;
    rst = 1; tick(); rst = 0;

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < N; c++) begin
        if (m_gnow && m_owner == c) req[c] = 1'b0;
        else if (!req[c]) req[c] = ($urandom_range(0, 7) == 0);
        else if ($urandom_range(0, 63) == 0) req[c] = 1'b0;
      end
      fin = ($urandom_range(0, 3) == 0);
      st = 1'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
